// File: rtl/counter_mod_n_pkg.sv
// Shared types for the mod-N counter.
//   mode_t  : counting behaviour at a bound (wrap / saturate / one-shot / reserved=wrap)
//   state_t : one-shot control state
//   mode_wraps() : true for the modes that wrap at a bound
package counter_pkg;

    typedef enum logic [1:0] {
        WRAP    = 2'b00,
        SAT     = 2'b01,
        ONESHOT = 2'b10,
        RSVD    = 2'b11
    } mode_t;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    // The reserved encoding behaves exactly like WRAP.
    function automatic logic mode_wraps(input mode_t m);
        return (m == WRAP) || (m == RSVD);
    endfunction

endpackage

// File: rtl/counter_mod_n_if.sv
// Control/status bundle of the mod-N counter.
//   clear, load, data_in, counter_on, count_up, mode : requests into the counter
//   Count, tc, wrap_pulse, ovf, done                  : counter status
// master = requester side, slave = counter side.
interface counter_mod_n_if #(
    parameter int NBITS = 4
);
    logic             clear;
    logic             load;
    logic [NBITS-1:0] data_in;
    logic             counter_on;
    logic             count_up;
    logic [1:0]       mode;
    logic [NBITS-1:0] Count;
    logic             tc;
    logic             wrap_pulse;
    logic             ovf;
    logic             done;

    modport master (
        output clear, load, data_in, counter_on, count_up, mode,
        input  Count, tc, wrap_pulse, ovf, done
    );

    modport slave (
        input  clear, load, data_in, counter_on, count_up, mode,
        output Count, tc, wrap_pulse, ovf, done
    );
endinterface

// File: rtl/counter_mod_n_next_val.sv
// Combinational next-count calculator for the mod-N counter.
//   count_i      : current count
//   count_up_i   : direction (1 = up)
//   mode_i       : bound behaviour
//   next_count_o : value the counter takes when enabled
//   wrap_o       : at the bound in the counting direction and the mode wraps
//   sat_o        : at the bound in the counting direction and the mode holds
module counter_next_val
    import counter_pkg::*;
#(
    parameter int NBITS   = 4,
    parameter int MODULUS = 2**NBITS
) (
    input  logic [NBITS-1:0] count_i,
    input  logic             count_up_i,
    input  mode_t            mode_i,
    output logic [NBITS-1:0] next_count_o,
    output logic             wrap_o,
    output logic             sat_o
);
    localparam logic [NBITS-1:0] MAXV = NBITS'(MODULUS - 1);

    logic at_bound;

    always_comb begin
        at_bound = count_up_i ? (count_i == MAXV) : (count_i == '0);
        wrap_o   = at_bound && mode_wraps(mode_i);
        sat_o    = at_bound && !mode_wraps(mode_i);
        if (!at_bound) begin
            next_count_o = count_up_i ? (count_i + NBITS'(1)) : (count_i - NBITS'(1));
        end else if (wrap_o) begin
            next_count_o = count_up_i ? '0 : MAXV;
        end else begin
            next_count_o = count_i;
        end
    end
endmodule

// File: rtl/counter_mod_n.sv
// Mod-N up/down counter with wrap, saturate and one-shot modes.
//   clk_2 : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : slave side of counter_mod_n_if (controls in, Count/tc/wrap_pulse/ovf/done out)
// Priority per edge: clear > load > counter_on > hold.
module counter_mod_n
    import counter_pkg::*;
#(
    parameter int NBITS   = 4,
    parameter int MODULUS = 2**NBITS
) (
    input logic              clk_2,
    input logic              reset,
    counter_mod_n_if.slave   bus
);
    if (NBITS < 1 || MODULUS < 2 || MODULUS > (2**NBITS)) begin : g_bad_param
        $error("counter_mod_n: MODULUS must satisfy 2 <= MODULUS <= 2**NBITS");
    end

    localparam logic [NBITS-1:0] MAXV    = NBITS'(MODULUS - 1);
    localparam logic [NBITS:0]   MOD_EXT = (NBITS + 1)'(MODULUS);

    state_t           state_q, state_d;
    logic [NBITS-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic             ovf_q,   ovf_d;
    logic             done_q,  done_d;

    mode_t            mode;
    logic [NBITS-1:0] nv_count;
    logic             nv_wrap;
    logic             nv_sat;
    logic [NBITS-1:0] load_val;
    logic             run_step;

    assign mode = mode_t'(bus.mode);

    counter_next_val #(
        .NBITS   (NBITS),
        .MODULUS (MODULUS)
    ) u_next_val (
        .count_i      (count_q),
        .count_up_i   (bus.count_up),
        .mode_i       (mode),
        .next_count_o (nv_count),
        .wrap_o       (nv_wrap),
        .sat_o        (nv_sat)
    );

    // Compare one bit wider so MODULUS == 2**NBITS never clamps.
    assign load_val = ({1'b0, bus.data_in} >= MOD_EXT) ? MAXV : bus.data_in;
    assign run_step = (state_q == RUN) && bus.counter_on;

    // State register
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.clear || bus.load) begin
            state_d = RUN;
        end else if (state_q == DONE) begin
            // Leaving one-shot releases the hold; counting restarts the edge after.
            if (mode != ONESHOT) begin
                state_d = RUN;
            end
        end else if (bus.counter_on && nv_sat && mode == ONESHOT) begin
            state_d = DONE;
        end
    end

    // Output / datapath next values
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        done_d  = (state_d == DONE);
        if (bus.clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            count_d = load_val;
        end else if (run_step) begin
            count_d = nv_count;
            wrap_d  = nv_wrap;
            // One-shot completion is not an overflow; wrap and saturate are.
            if (nv_wrap || (nv_sat && mode == SAT)) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.Count      = count_q;
    assign bus.tc         = bus.counter_on && (nv_wrap || nv_sat);
    assign bus.wrap_pulse = wrap_q;
    assign bus.ovf        = ovf_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_counter_mod_n.sv
// Self-checking bench for counter_mod_n (NBITS=4, MODULUS=10): directed
// scenarios followed by randomized stimulus against an arithmetic model.
module tb_counter_mod_n;
    localparam int NB = 4;
    localparam int M  = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    counter_mod_n_if #(.NBITS(NB)) bus ();

    counter_mod_n #(
        .NBITS   (NB),
        .MODULUS (M)
    ) dut (
        .clk_2 (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int m_cnt;
    bit m_wrap;
    bit m_ovf;
    bit m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic model_tc();
        return bus.counter_on && (bus.count_up ? (m_cnt == M - 1) : (m_cnt == 0));
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_wrap = 0;
        m_ovf  = 0;
        m_done = 0;
    endtask

    task automatic model_step();
        int d;
        m_wrap = 0;
        if (bus.clear) begin
            m_cnt  = 0;
            m_ovf  = 0;
            m_done = 0;
        end else if (bus.load) begin
            m_cnt  = (int'(bus.data_in) < M) ? int'(bus.data_in) : M - 1;
            m_done = 0;
        end else if (m_done) begin
            if (bus.mode != 2'b10) m_done = 0;
        end else if (bus.counter_on) begin
            d = bus.count_up ? 1 : -1;
            if (m_cnt + d >= 0 && m_cnt + d < M) begin
                m_cnt = m_cnt + d;
            end else begin
                case (bus.mode)
                    2'b01:   m_ovf = 1;
                    2'b10:   m_done = 1;
                    default: begin
                        m_cnt  = (m_cnt + d + M) % M;
                        m_wrap = 1;
                        m_ovf  = 1;
                    end
                endcase
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cnt"},  bus.Count,      m_cnt);
        chk({tag, ".wrap"}, bus.wrap_pulse, m_wrap);
        chk({tag, ".ovf"},  bus.ovf,        m_ovf);
        chk({tag, ".done"}, bus.done,       m_done);
        chk({tag, ".tc"},   bus.tc,         model_tc());
    endtask

    task automatic drive(input bit clr, input bit ld, input int din,
                         input bit on, input bit up, input bit [1:0] md);
        bus.clear      = clr;
        bus.load       = ld;
        bus.data_in    = 4'(din);
        bus.counter_on = on;
        bus.count_up   = up;
        bus.mode       = md;
    endtask

    task automatic tick(input string tag);
        if (reset) model_reset();
        else       model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 1, 0, 2'b00);
        model_reset();

        // Asynchronous reset before any clock edge; tc=1 with counter_on=1, count_up=0
        #1 reset = 1'b1;
        #2;
        check_all("rst_async");
        chk("rst_tc", bus.tc, 1);
        tick("rst_hold");
        reset = 1'b0;

        // Wrap up from 9
        drive(0, 1, 9, 0, 1, 2'b00);
        tick("w_ld9");
        drive(0, 0, 0, 1, 1, 2'b00);
        #1 chk("w_tc", bus.tc, 1);
        tick("w_edge");
        chk("w_cnt", bus.Count, 0);
        chk("w_pulse", bus.wrap_pulse, 1);
        chk("w_ovf", bus.ovf, 1);
        drive(0, 0, 0, 0, 1, 2'b00);
        tick("w_after");
        chk("w_pulse_gone", bus.wrap_pulse, 0);

        // Saturate down at 0, then reverse
        drive(1, 0, 0, 0, 0, 2'b01);
        tick("s_clr");
        chk("s_clr_ovf", bus.ovf, 0);
        drive(0, 0, 0, 1, 0, 2'b01);
        repeat (3) tick("s_hold");
        chk("s_cnt", bus.Count, 0);
        chk("s_pulse", bus.wrap_pulse, 0);
        chk("s_ovf", bus.ovf, 1);
        bus.count_up = 1'b1;
        tick("s_rev");
        chk("s_rev_cnt", bus.Count, 1);

        // One-shot from 7
        drive(0, 1, 7, 1, 1, 2'b10);
        tick("o_ld7");
        drive(0, 0, 0, 1, 1, 2'b10);
        tick("o_e1");
        chk("o_e1_cnt", bus.Count, 8);
        tick("o_e2");
        chk("o_e2_cnt", bus.Count, 9);
        tick("o_e3");
        tick("o_e4");
        chk("o_e4_cnt", bus.Count, 9);
        chk("o_e4_done", bus.done, 1);
        drive(0, 1, 3, 1, 1, 2'b10);
        tick("o_ld3");
        chk("o_ld3_done", bus.done, 0);
        chk("o_ld3_cnt", bus.Count, 3);

        // Load clamp and clear-over-load priority
        drive(0, 1, 13, 0, 1, 2'b00);
        tick("l_clamp");
        chk("l_clamp_cnt", bus.Count, 9);
        drive(1, 1, 5, 1, 1, 2'b00);
        tick("l_prio");
        chk("l_prio_cnt", bus.Count, 0);

        // Async reset while in DONE with ovf set
        drive(0, 1, 0, 0, 0, 2'b00);
        tick("r_ld0");
        drive(0, 0, 0, 1, 0, 2'b00);
        tick("r_under");
        drive(0, 0, 0, 1, 1, 2'b10);
        tick("r_done");
        chk("r_done_flag", bus.done, 1);
        chk("r_ovf_flag", bus.ovf, 1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("r_async");
        chk("r_async_cnt", bus.Count, 0);
        reset = 1'b0;

        // Leaving one-shot from DONE at 9
        drive(0, 1, 8, 1, 1, 2'b10);
        tick("x_ld8");
        drive(0, 0, 0, 1, 1, 2'b10);
        tick("x_e9");
        tick("x_done");
        chk("x_done_flag", bus.done, 1);
        bus.mode = 2'b00;
        tick("x_exit");
        chk("x_exit_done", bus.done, 0);
        chk("x_exit_cnt", bus.Count, 9);
        tick("x_wrap");
        chk("x_wrap_cnt", bus.Count, 0);
        chk("x_wrap_pulse", bus.wrap_pulse, 1);

        // Randomized traffic
        drive(0, 0, 0, 1, 1, 2'b00);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                check_all("rnd_rst");
                reset = 1'b0;
                #1;
            end
            bus.clear      = ($urandom_range(0, 24) == 0);
            bus.load       = ($urandom_range(0, 11) == 0);
            bus.data_in    = 4'($urandom);
            bus.counter_on = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) bus.count_up = ~bus.count_up;
            if ($urandom_range(0, 9) == 0) bus.mode = 2'($urandom);
            #1 chk("rnd_tc", bus.tc, model_tc());
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
